// File: rtl/traffic_light_fsm_pkg.sv
// Shared types and constants for the intersection light controller.
// Optional feature macro: FSM_WALK_EN adds the pedestrian WALK phase.
package traffic_light_fsm_pkg;

  // Light phases; WALK only exists when the pedestrian phase is built in.
  typedef enum logic [2:0] {
    S_MG_BASE = 3'd0,
    S_MG_EXT  = 3'd1,
    S_MY      = 3'd2,
    S_SG_BASE = 3'd3,
    S_SG_EXT  = 3'd4,
`ifdef FSM_WALK_EN
    S_SY      = 3'd5,
    S_WALK    = 3'd6
`else
    S_SY      = 3'd5
`endif
  } state_t;

  // Timer interval select codes
  localparam logic [1:0] INT_BASE = 2'b00;
  localparam logic [1:0] INT_EXT  = 2'b01;
  localparam logic [1:0] INT_YEL  = 2'b10;
  localparam logic [1:0] INT_WALK = 2'b11;

  // Lamp bit positions inside lights[7:0]
  localparam int LAMP_MAIN_LSB = 0;
  localparam int LAMP_SIDE_LSB = 3;
  localparam int LAMP_WALK1    = 6;
  localparam int LAMP_WALK2    = 7;

  // Per-road lamp patterns, ordered {R,Y,G}
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  // Interval code that a phase requests from the timer for its whole duration.
  function automatic logic [1:0] state_interval(input state_t s);
    logic [1:0] code;
    case (s)
      S_MG_BASE: code = INT_BASE;
      S_SG_BASE: code = INT_BASE;
      S_MG_EXT:  code = INT_EXT;
      S_SG_EXT:  code = INT_EXT;
      S_MY:      code = INT_YEL;
      S_SY:      code = INT_YEL;
`ifdef FSM_WALK_EN
      S_WALK:    code = INT_WALK;
`endif
      default:   code = INT_BASE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/traffic_light_decode.sv
// Decodes the phase register (and latched walk requests) into lamp drives.
// Optional feature macro: FSM_WALK_EN enables the walk lamp inputs.
module traffic_light_decode
  import traffic_light_fsm_pkg::*;
(
  input  state_t      i_state,
`ifdef FSM_WALK_EN
  input  logic [1:0]  i_walk,
`endif
  output logic [7:0]  o_lights
);

  logic [2:0] w_main;
  logic [2:0] w_side;
  logic [1:0] w_walk;

  // Only one road may show green/yellow; everything else falls back to red.
  always_comb begin
    w_main = LAMP_RED;
    w_side = LAMP_RED;
    w_walk = 2'b00;
    case (i_state)
      S_MG_BASE: w_main = LAMP_GRN;
      S_MG_EXT:  w_main = LAMP_GRN;
      S_MY:      w_main = LAMP_YEL;
      S_SG_BASE: w_side = LAMP_GRN;
      S_SG_EXT:  w_side = LAMP_GRN;
      S_SY:      w_side = LAMP_YEL;
`ifdef FSM_WALK_EN
      S_WALK:    w_walk = i_walk;
`endif
      default: begin
        w_main = LAMP_RED;
        w_side = LAMP_RED;
        w_walk = 2'b00;
      end
    endcase
  end

  assign o_lights[LAMP_MAIN_LSB +: 3] = w_main;
  assign o_lights[LAMP_SIDE_LSB +: 3] = w_side;
  assign o_lights[LAMP_WALK1]         = w_walk[0];
  assign o_lights[LAMP_WALK2]         = w_walk[1];

endmodule

// File: rtl/traffic_light_fsm.sv
// Main/side intersection controller handshaking with an external interval timer.
// Each phase loads the timer once (start_timer pulse) and moves on when it expires.
// Optional feature macro: FSM_WALK_EN adds the pedestrian WALK phase and WR_Reset.
module traffic_light_fsm
  import traffic_light_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        g_reset,
  input  logic        sensor_sync,
  input  logic        WR_Out_1,
  input  logic        WR_Out_2,
  input  logic        prog_sync,
  input  logic        expired,
  output logic        WR_Reset,
  output logic [1:0]  interval,
  output logic        start_timer,
  output logic [7:0]  lights
);

  state_t     r_state;
  logic [1:0] r_interval;
  logic       r_start_timer;
  logic       r_restart;
  state_t     w_adv_state;

`ifdef FSM_WALK_EN
  logic [1:0] r_walk;
  logic       r_wr_reset;
  logic       w_in_walk;

  assign w_in_walk = (r_state == S_WALK);
`else
  // Walk requests have no consumer when the pedestrian phase is absent.
  logic       w_unused_walk_req;

  assign w_unused_walk_req = WR_Out_1 ^ WR_Out_2;
`endif

  // Phase that follows the current one when its timer interval has elapsed.
  always_comb begin
    w_adv_state = r_state;
    case (r_state)
      S_MG_BASE: w_adv_state = sensor_sync ? S_MY : S_MG_EXT;
      S_MG_EXT:  w_adv_state = S_MY;
      S_MY:      w_adv_state = S_SG_BASE;
      S_SG_BASE: w_adv_state = sensor_sync ? S_SG_EXT : S_SY;
      S_SG_EXT:  w_adv_state = S_SY;
`ifdef FSM_WALK_EN
      S_SY:      w_adv_state = (WR_Out_1 | WR_Out_2) ? S_WALK : S_MG_BASE;
      S_WALK:    w_adv_state = S_MG_BASE;
`else
      S_SY:      w_adv_state = S_MG_BASE;
`endif
      default:   w_adv_state = S_MG_BASE;
    endcase
  end

  // Phase register with timer handshake; a restart (reset or reprogram) beats a
  // timer expiry, and expiry is ignored in the cycle the timer is being loaded
  // so a level-held expired advances only one phase per timer round trip.
  always_ff @(posedge clk) begin
    if (!g_reset) begin
      r_state       <= S_MG_BASE;
      r_interval    <= INT_BASE;
      r_start_timer <= 1'b0;
      r_restart     <= 1'b1;
`ifdef FSM_WALK_EN
      r_walk        <= 2'b00;
      r_wr_reset    <= 1'b0;
`endif
    end else if (r_restart || prog_sync) begin
      r_state       <= S_MG_BASE;
      r_interval    <= INT_BASE;
      r_start_timer <= 1'b1;
      r_restart     <= 1'b0;
`ifdef FSM_WALK_EN
      r_walk        <= 2'b00;
      r_wr_reset    <= w_in_walk;
`endif
    end else if (expired && !r_start_timer) begin
      r_state       <= w_adv_state;
      r_interval    <= state_interval(w_adv_state);
      r_start_timer <= 1'b1;
      r_restart     <= 1'b0;
`ifdef FSM_WALK_EN
      // Walk lamps reflect the requests pending at the moment WALK is entered.
      if (w_adv_state == S_WALK) begin
        r_walk <= {WR_Out_2, WR_Out_1};
      end else begin
        r_walk <= 2'b00;
      end
      r_wr_reset    <= w_in_walk;
`endif
    end else begin
      r_start_timer <= 1'b0;
      r_restart     <= 1'b0;
`ifdef FSM_WALK_EN
      r_wr_reset    <= 1'b0;
`endif
    end
  end

  assign interval    = r_interval;
  assign start_timer = r_start_timer;
`ifdef FSM_WALK_EN
  assign WR_Reset    = r_wr_reset;
`else
  assign WR_Reset    = 1'b0;
`endif

  traffic_light_decode u_decode (
    .i_state  (r_state),
`ifdef FSM_WALK_EN
    .i_walk   (r_walk),
`endif
    .o_lights (lights)
  );

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Self-checking bench for traffic_light_fsm: directed vector table, corner
// sequences, and a randomized run against a phase-level reference model.
module tb_traffic_light_fsm;

  logic       clk = 1'b0;
  logic       g_reset = 1'b0;
  logic       sensor_sync = 1'b0;
  logic       WR_Out_1 = 1'b0;
  logic       WR_Out_2 = 1'b0;
  logic       prog_sync = 1'b0;
  logic       expired = 1'b0;
  logic       WR_Reset;
  logic [1:0] interval;
  logic       start_timer;
  logic [7:0] lights;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_light_fsm dut (
    .clk         (clk),
    .g_reset     (g_reset),
    .sensor_sync (sensor_sync),
    .WR_Out_1    (WR_Out_1),
    .WR_Out_2    (WR_Out_2),
    .prog_sync   (prog_sync),
    .expired     (expired),
    .WR_Reset    (WR_Reset),
    .interval    (interval),
    .start_timer (start_timer),
    .lights      (lights)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] L_MG = 8'b00_100_001;
  localparam logic [7:0] L_MY = 8'b00_100_010;
  localparam logic [7:0] L_SG = 8'b00_001_100;
  localparam logic [7:0] L_SY = 8'b00_010_100;
  localparam logic [7:0] L_WK = 8'b11_100_100;

  // ---------------- reference model (phase level) ----------------
  localparam int P_MGB = 0, P_MGE = 1, P_MY = 2, P_SGB = 3, P_SGE = 4, P_SY = 5, P_WALK = 6;
  localparam logic [2:0] C_R = 3'b100, C_Y = 3'b010, C_G = 3'b001;

  int m_ph = P_MGB;
  bit m_st = 1'b0, m_wr = 1'b0, m_restart = 1'b1, m_w1 = 1'b0, m_w2 = 1'b0;

  function automatic logic [7:0] model_lights();
    logic [2:0] mn, sd;
    logic [1:0] wk;
    mn = C_R; sd = C_R; wk = 2'b00;
    if (m_ph == P_MGB || m_ph == P_MGE) mn = C_G;
    if (m_ph == P_MY) mn = C_Y;
    if (m_ph == P_SGB || m_ph == P_SGE) sd = C_G;
    if (m_ph == P_SY) sd = C_Y;
    if (m_ph == P_WALK) wk = {m_w2, m_w1};
    return {wk, sd, mn};
  endfunction

  function automatic logic [1:0] model_interval();
    if (m_ph == P_WALK) return 2'd3;
    if (m_ph == P_MGE || m_ph == P_SGE) return 2'd1;
    if (m_ph == P_MY || m_ph == P_SY) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_edge(input bit rst, prog, exp, sen, w1, w2);
    int nx;
    if (!rst) begin
      m_ph = P_MGB; m_st = 1'b0; m_wr = 1'b0; m_restart = 1'b1; m_w1 = 1'b0; m_w2 = 1'b0;
    end else if (m_restart || prog) begin
      m_wr = (m_ph == P_WALK);
      m_ph = P_MGB; m_st = 1'b1; m_restart = 1'b0;
    end else if (exp && !m_st) begin
      case (m_ph)
        P_MGB:   nx = sen ? P_MY : P_MGE;
        P_MGE:   nx = P_MY;
        P_MY:    nx = P_SGB;
        P_SGB:   nx = sen ? P_SGE : P_SY;
        P_SGE:   nx = P_SY;
`ifdef FSM_WALK_EN
        P_SY:    nx = (w1 || w2) ? P_WALK : P_MGB;
`else
        P_SY:    nx = P_MGB;
`endif
        default: nx = P_MGB;
      endcase
      m_wr = (m_ph == P_WALK);
      if (nx == P_WALK) begin m_w1 = w1; m_w2 = w2; end
      m_ph = nx; m_st = 1'b1;
    end else begin
      m_st = 1'b0; m_wr = 1'b0;
    end
  endtask

  // ---------------- drive / compare helpers ----------------
  task automatic step(input bit rst, prog, exp, sen, w1, w2);
    g_reset = rst; prog_sync = prog; expired = exp; sensor_sync = sen;
    WR_Out_1 = w1; WR_Out_2 = w2;
    @(posedge clk);
    model_edge(rst, prog, exp, sen, w1, w2);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [7:0] el, input logic [1:0] ei,
                       input logic est, input logic ewr);
    n_checks++;
    if (lights !== el || interval !== ei || start_timer !== est || WR_Reset !== ewr) begin
      n_fail++;
      $display("FAIL %s: got lights=%b interval=%b start_timer=%b WR_Reset=%b, want lights=%b interval=%b start_timer=%b WR_Reset=%b",
               name, lights, interval, start_timer, WR_Reset, el, ei, est, ewr);
    end
  endtask

  task automatic check_model(input string name);
    check(name, model_lights(), model_interval(), m_st, m_wr);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rst, prog, exp, sen, w1, w2;
    logic [7:0] el;
    logic [1:0] ei;
    logic est, ewr;
  } vec_t;

  function automatic vec_t mk(input bit rst, prog, exp, sen, input logic [7:0] el,
                              input logic [1:0] ei, input logic est);
    vec_t v;
    v.rst = rst; v.prog = prog; v.exp = exp; v.sen = sen; v.w1 = 1'b0; v.w2 = 1'b0;
    v.el = el; v.ei = ei; v.est = est; v.ewr = 1'b0;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    int pulses;
    bit prev_st;
    bit rst_r;

    //           rst  prog exp  sen
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, L_MG, 2'b00, 1'b0)); // reset
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, L_MG, 2'b00, 1'b0)); // reset
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, L_MG, 2'b00, 1'b1)); // restart pulse
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, L_MG, 2'b00, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, L_MG, 2'b01, 1'b1)); // -> MG_EXT
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, L_MG, 2'b01, 1'b0)); // expired ignored
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, L_MG, 2'b01, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, L_MY, 2'b10, 1'b1)); // -> MY
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, L_MY, 2'b10, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, L_SG, 2'b00, 1'b1)); // -> SG_BASE
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, L_SG, 2'b00, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, L_SG, 2'b01, 1'b1)); // -> SG_EXT
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, L_SG, 2'b01, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, L_SY, 2'b10, 1'b1)); // -> SY
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, L_SY, 2'b10, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, L_MG, 2'b00, 1'b1)); // -> MG_BASE
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, L_MG, 2'b00, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, L_MY, 2'b10, 1'b1)); // sensor skips EXT
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, L_MY, 2'b10, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, L_MG, 2'b00, 1'b1)); // prog from MY
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, L_MG, 2'b00, 1'b1)); // prog in MG_BASE
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, L_MG, 2'b00, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, L_MG, 2'b00, 1'b1)); // prog beats expired
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, L_MG, 2'b00, 1'b0)); // reset beats all
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, L_MG, 2'b00, 1'b1)); // restart beats expired
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, L_MG, 2'b00, 1'b0));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].prog, vecs[i].exp, vecs[i].sen, vecs[i].w1, vecs[i].w2);
      check($sformatf("vec[%0d]", i), vecs[i].el, vecs[i].ei, vecs[i].est, vecs[i].ewr);
    end

    // Walk sequence: MG_BASE -> MG_EXT -> MY -> SG_BASE -> SY, then requests pending.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("reach_sy", L_SY, 2'b10, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
`ifdef FSM_WALK_EN
    check("walk_entry", L_WK, 2'b11, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("walk_hold", L_WK, 2'b11, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("walk_exit", L_MG, 2'b00, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("wr_reset_single", L_MG, 2'b00, 1'b0, 1'b0);
`else
    check("sy_no_walk", L_MG, 2'b00, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sy_no_walk_idle", L_MG, 2'b00, 1'b0, 1'b0);
`endif

    // prog_sync inside SG_EXT: MG_BASE -> MY -> SG_BASE -> SG_EXT then reprogram.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("reach_sg_ext", L_SG, 2'b01, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("prog_in_sg_ext", L_MG, 2'b00, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef FSM_WALK_EN
    // prog_sync inside WALK (only walk1 requested) must also clear the walk registers.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("walk1_only", 8'b01_100_100, 2'b11, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("walk_latched", 8'b01_100_100, 2'b11, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("prog_in_walk", L_MG, 2'b00, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    // expired held high for 30 cycles: one phase per timer load, never back-to-back.
    pulses = 0;
    prev_st = start_timer;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_model($sformatf("held[%0d]", i));
      if (start_timer === 1'b1) pulses++;
      if (prev_st && start_timer === 1'b1) begin
        n_checks++; n_fail++;
        $display("FAIL held_b2b: start_timer high two cycles in a row at cycle %0d, want single pulses", i);
      end
      prev_st = start_timer;
    end
    n_checks++;
    if (pulses != 15) begin
      n_fail++;
      $display("FAIL held_pulses: got %0d start_timer pulses, want 15", pulses);
    end

    // Randomized run against the reference model.
    for (int i = 0; i < 600; i++) begin
      rst_r = ($urandom_range(0, 79) != 0);
      step(rst_r, $urandom_range(0, 29) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      check_model($sformatf("rand[%0d]", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
